// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder for the memory stage of a RV32I pipeline.
// It accepts one load or store at a time, applies byte/half/word lane steering
// selected by Funct3, holds Busy for LATENCY cycles, then either commits the
// store or returns the aligned and extended load word with a ReadValid pulse.
// Malformed requests are rejected with a single-cycle Fault pulse.
//
// Parameters
//   ADDR_WIDTH : word-address bits, storage is 2^ADDR_WIDTH x 32-bit words
//   LATENCY    : cycles from acceptance to commit/response (1..15)
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous active-low reset
//   MemRead    : load request
//   MemWrite   : store request
//   Funct3     : RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   Address    : byte address, upper bits beyond the storage wrap
//   WriteData  : right-justified store data
//   Busy       : high while a request is in flight
//   ReadData   : extended load result, held until the next ReadValid
//   ReadValid  : one-cycle pulse when ReadData is updated
//   Fault      : one-cycle pulse for a rejected request

module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Fault
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [3:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_wordAddr;
  logic [1:0]            r_lane;
  logic [2:0]            r_funct3;
  logic [31:0]           r_wdata;
  logic                  r_isStore;

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  logic        w_reqAny;
  logic        w_reqBoth;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_reject;
  logic        w_commit;
  logic [31:0] w_wordRd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;
  logic [3:0]  w_byteEn;
  logic [31:0] w_storeData;

  // Address bits above the storage range are intentionally dropped (wrap).
  logic w_unusedAddrBits;
  assign w_unusedAddrBits = ^Address[31:ADDR_WIDTH+2];

  assign Busy = (r_state == ACCESS);

  // Request classification. Stores have no unsigned variants, so any store
  // with Funct3[2] set is as illegal as the three unused codes.
  always_comb begin
    w_reqAny     = MemRead | MemWrite;
    w_reqBoth    = MemRead & MemWrite;
    w_illegal    = (Funct3 == 3'b011) | (Funct3 == 3'b110) | (Funct3 == 3'b111)
                 | (MemWrite & Funct3[2]);
    w_misaligned = ((Funct3[1:0] == 2'b01) & Address[0])
                 | ((Funct3[1:0] == 2'b10) & (Address[1:0] != 2'b00));
  end

  // Next-state logic: accept or reject in IDLE, finish ACCESS when the
  // down-counter reaches zero.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_reqAny) begin
          if (w_reqBoth | w_illegal | w_misaligned) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_nextState = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (r_count == 4'd0) begin
          w_commit    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Load lane extraction from the latched byte lane.
  always_comb begin
    w_wordRd = r_mem[r_wordAddr];
    w_byte   = w_wordRd[{r_lane, 3'b000} +: 8];
    w_half   = r_lane[1] ? w_wordRd[31:16] : w_wordRd[15:0];
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b100:  w_loadData = {24'h000000, w_byte};
      3'b101:  w_loadData = {16'h0000, w_half};
      default: w_loadData = w_wordRd;
    endcase
  end

  // Store lane steering: replicate the right-justified data across the word
  // so the byte enables alone pick which lanes land.
  always_comb begin
    case (r_funct3[1:0])
      2'b00: begin
        w_byteEn    = 4'b0001 << r_lane;
        w_storeData = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_byteEn    = r_lane[1] ? 4'b1100 : 4'b0011;
        w_storeData = {2{r_wdata[15:0]}};
      end
      default: begin
        w_byteEn    = 4'b1111;
        w_storeData = r_wdata;
      end
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_count <= 4'(LATENCY - 1);
      end else if ((r_state == ACCESS) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  // Request capture; only meaningful while in ACCESS, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wordAddr <= Address[ADDR_WIDTH+1:2];
      r_lane     <= Address[1:0];
      r_funct3   <= Funct3;
      r_wdata    <= WriteData;
      r_isStore  <= MemWrite;
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ReadData  <= 32'h0;
      ReadValid <= 1'b0;
      Fault     <= 1'b0;
    end else begin
      ReadValid <= w_commit & ~r_isStore;
      Fault     <= w_reject;
      if (w_commit & ~r_isStore) begin
        ReadData <= w_loadData;
      end
    end
  end

  // Storage. Reset gates the commit so an interrupted store never lands,
  // but the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (reset && w_commit && r_isStore) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byteEn[b]) begin
          r_mem[r_wordAddr][8*b +: 8] <= w_storeData[8*b +: 8];
        end
      end
    end
  end

endmodule
